// File: rtl/lsu_dc_fill_ctl.sv
// Data-cache line fill controller: issues one bus read per miss, writes four 64-bit beats
// with per-halfword parity, then writes the tag. Define RV_DC_FILL_CWF_EN for critical-word-first.
module lsu_dc_fill_ctl #(
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [29:0]         miss_addr,
  input  logic [NUM_WAYS-1:0] miss_way,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [28:0]         bus_req_addr,
  input  logic                bus_rsp_valid,
  input  logic [63:0]         bus_rsp_data,
  input  logic                bus_rsp_err,
  output logic [29:0]         dc_rw_addr,
  output logic [NUM_WAYS-1:0] dc_wr_en,
  output logic [67:0]         dc_wr_data,
  output logic [29:0]         dc_rw_tag_addr,
  output logic [NUM_WAYS-1:0] lsu_dc_tag_wren,
  output logic                dc_tag_valid_wr,
  output logic                crit_valid,
  output logic [63:0]         crit_data,
  output logic                fill_done,
  output logic                fill_err
);

  localparam int unsigned ADDR_W  = 30;
  localparam int unsigned LINE_W  = 27;
  localparam int unsigned BUS_AW  = 29;
  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned WORD_W  = 68;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    TAG  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [IDX_W-1:0]    off_q, off_d;
  logic [NUM_WAYS-1:0] way_q, way_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                miss_ready_q, miss_ready_d;
  logic                bus_req_valid_q, bus_req_valid_d;
  logic [BUS_AW-1:0]   bus_req_addr_q, bus_req_addr_d;
  logic [ADDR_W-1:0]   dc_rw_addr_q, dc_rw_addr_d;
  logic [NUM_WAYS-1:0] dc_wr_en_q, dc_wr_en_d;
  logic [WORD_W-1:0]   dc_wr_data_q, dc_wr_data_d;
  logic [ADDR_W-1:0]   tag_addr_q, tag_addr_d;
  logic [NUM_WAYS-1:0] tag_wren_q, tag_wren_d;
  logic                tag_valid_q, tag_valid_d;
  logic                crit_valid_q, crit_valid_d;
  logic [BEAT_W-1:0]   crit_data_q, crit_data_d;
  logic                fill_done_q, fill_done_d;
  logic                fill_err_q, fill_err_d;

  logic                miss_fire;
  logic [IDX_W-1:0]    start_idx;
  logic [BUS_AW-1:0]   req_addr;
  logic                unused_addr_bit;

  // Even parity over each 16-bit half of a 32-bit word: {hi half, lo half}.
  function automatic logic [1:0] par32(input logic [31:0] d);
    par32 = {^d[31:16], ^d[15:0]};
  endfunction

  assign miss_fire       = miss_valid && miss_ready_q;
  assign unused_addr_bit = miss_addr[0];

`ifdef RV_DC_FILL_CWF_EN
  assign start_idx = miss_addr[2:1];
  assign req_addr  = miss_addr[29:1];
`else
  assign start_idx = IDX_W'(0);
  assign req_addr  = {miss_addr[29:3], 2'b00};
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    off_d           = off_q;
    way_d           = way_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    bus_req_valid_d = bus_req_valid_q;
    bus_req_addr_d  = bus_req_addr_q;
    dc_rw_addr_d    = dc_rw_addr_q;
    dc_wr_en_d      = '0;
    dc_wr_data_d    = dc_wr_data_q;
    tag_addr_d      = tag_addr_q;
    tag_wren_d      = '0;
    tag_valid_d     = 1'b0;
    crit_valid_d    = 1'b0;
    crit_data_d     = crit_data_q;
    fill_done_d     = 1'b0;
    fill_err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_fire) begin
          state_d         = REQ;
          line_d          = miss_addr[29:3];
          off_d           = miss_addr[2:1];
          way_d           = miss_way;
          idx_d           = start_idx;
          cnt_d           = IDX_W'(0);
          err_d           = 1'b0;
          bus_req_valid_d = 1'b1;
          bus_req_addr_d  = req_addr;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d         = FILL;
          bus_req_valid_d = 1'b0;
        end
      end
      FILL: begin
        if (bus_rsp_valid) begin
          dc_wr_en_d   = way_q;
          dc_rw_addr_d = {line_q, idx_q, 1'b0};
          dc_wr_data_d = {par32(bus_rsp_data[63:32]), bus_rsp_data[63:32],
                          par32(bus_rsp_data[31:0]),  bus_rsp_data[31:0]};
          if (idx_q == off_q) begin
            crit_valid_d = 1'b1;
            crit_data_d  = bus_rsp_data;
          end
          err_d = err_q | bus_rsp_err;
          idx_d = idx_q + IDX_W'(1);
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(3)) begin
            state_d = TAG;
          end
        end
      end
      TAG: begin
        // An errored line is still written, but its tag is left invalid.
        tag_wren_d  = way_q;
        tag_addr_d  = {line_q, 3'b000};
        tag_valid_d = ~err_q;
        fill_done_d = 1'b1;
        fill_err_d  = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ready only once the controller has settled in IDLE for a full cycle.
    miss_ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q         <= IDLE;
      line_q          <= '0;
      off_q           <= '0;
      way_q           <= '0;
      idx_q           <= '0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      miss_ready_q    <= 1'b0;
      bus_req_valid_q <= 1'b0;
      bus_req_addr_q  <= '0;
      dc_rw_addr_q    <= '0;
      dc_wr_en_q      <= '0;
      dc_wr_data_q    <= '0;
      tag_addr_q      <= '0;
      tag_wren_q      <= '0;
      tag_valid_q     <= 1'b0;
      crit_valid_q    <= 1'b0;
      crit_data_q     <= '0;
      fill_done_q     <= 1'b0;
      fill_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      line_q          <= line_d;
      off_q           <= off_d;
      way_q           <= way_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      miss_ready_q    <= miss_ready_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_req_addr_q  <= bus_req_addr_d;
      dc_rw_addr_q    <= dc_rw_addr_d;
      dc_wr_en_q      <= dc_wr_en_d;
      dc_wr_data_q    <= dc_wr_data_d;
      tag_addr_q      <= tag_addr_d;
      tag_wren_q      <= tag_wren_d;
      tag_valid_q     <= tag_valid_d;
      crit_valid_q    <= crit_valid_d;
      crit_data_q     <= crit_data_d;
      fill_done_q     <= fill_done_d;
      fill_err_q      <= fill_err_d;
    end
  end

  assign miss_ready      = miss_ready_q;
  assign bus_req_valid   = bus_req_valid_q;
  assign bus_req_addr    = bus_req_addr_q;
  assign dc_rw_addr      = dc_rw_addr_q;
  assign dc_wr_en        = dc_wr_en_q;
  assign dc_wr_data      = dc_wr_data_q;
  assign dc_rw_tag_addr  = tag_addr_q;
  assign lsu_dc_tag_wren = tag_wren_q;
  assign dc_tag_valid_wr = tag_valid_q;
  assign crit_valid      = crit_valid_q;
  assign crit_data       = crit_data_q;
  assign fill_done       = fill_done_q;
  assign fill_err        = fill_err_q;

endmodule

// File: tb/tb_lsu_dc_fill_ctl.sv
// Directed self-checking bench for lsu_dc_fill_ctl; expectations follow RV_DC_FILL_CWF_EN when defined.
module tb_lsu_dc_fill_ctl;

`ifdef RV_DC_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l;
  logic        miss_valid;
  logic        miss_ready;
  logic [29:0] miss_addr;
  logic [3:0]  miss_way;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [28:0] bus_req_addr;
  logic        bus_rsp_valid;
  logic [63:0] bus_rsp_data;
  logic        bus_rsp_err;
  logic [29:0] dc_rw_addr;
  logic [3:0]  dc_wr_en;
  logic [67:0] dc_wr_data;
  logic [29:0] dc_rw_tag_addr;
  logic [3:0]  lsu_dc_tag_wren;
  logic        dc_tag_valid_wr;
  logic        crit_valid;
  logic [63:0] crit_data;
  logic        fill_done;
  logic        fill_err;

  int checks = 0;
  int errors = 0;
  logic [63:0] beats [4];

  lsu_dc_fill_ctl #(.NUM_WAYS(4)) dut (
    .clk(clk), .rst_l(rst_l),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr), .miss_way(miss_way),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err),
    .dc_rw_addr(dc_rw_addr), .dc_wr_en(dc_wr_en), .dc_wr_data(dc_wr_data),
    .dc_rw_tag_addr(dc_rw_tag_addr), .lsu_dc_tag_wren(lsu_dc_tag_wren),
    .dc_tag_valid_wr(dc_tag_valid_wr), .crit_valid(crit_valid), .crit_data(crit_data),
    .fill_done(fill_done), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  // Expected array word: {p_hi, d_hi, p_lo, d_lo}, even parity per 16-bit half.
  function automatic logic [67:0] wr_word(input logic [63:0] b);
    wr_word = {^b[63:48], ^b[47:32], b[63:32], ^b[31:16], ^b[15:0], b[31:0]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_miss(input logic [29:0] a, input logic [3:0] w);
    miss_valid = 1'b1;
    miss_addr  = a;
    miss_way   = w;
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic grant();
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (3) tick();
    checks++;
    if ({miss_ready, bus_req_valid, dc_wr_en, lsu_dc_tag_wren, crit_valid, fill_done, fill_err,
         dc_tag_valid_wr, bus_req_addr, dc_rw_addr, dc_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b req_v=%b wr_en=%b tag=%b crit=%b done=%b err=%b, all required 0",
               miss_ready, bus_req_valid, dc_wr_en, lsu_dc_tag_wren, crit_valid, fill_done, fill_err);
    end
    rst_l = 1'b1;
    tick();
    checks++;
    if (miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", miss_ready);
    end
  endtask

  task automatic test_clean_fill();
    logic [29:0] exp_a [4];
    int crit_b;
    if (CWF) begin
      exp_a = '{30'h402, 30'h404, 30'h406, 30'h400};
      crit_b = 0;
    end else begin
      exp_a = '{30'h400, 30'h402, 30'h404, 30'h406};
      crit_b = 1;
    end
    start_miss(30'h402, 4'b0010);
    checks++;
    if ({miss_ready, bus_req_valid, bus_req_addr} !== {1'b0, 1'b1, (CWF ? 29'h201 : 29'h200)}) begin
      errors++;
      $display("FAIL clean_req: ready=%b valid=%b addr=%h", miss_ready, bus_req_valid, bus_req_addr);
    end
    grant();
    checks++;
    if (bus_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_req_drop: got %b required 0", bus_req_valid);
    end
    for (int b = 0; b < 4; b++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = beats[b];
      bus_rsp_err   = 1'b0;
      tick();
      checks++;
      if ({dc_wr_en, dc_rw_addr, dc_wr_data} !== {4'b0010, exp_a[b], wr_word(beats[b])}) begin
        errors++;
        $display("FAIL clean_write%0d: en=%b addr=%h data=%h required en=0010 addr=%h data=%h",
                 b, dc_wr_en, dc_rw_addr, dc_wr_data, exp_a[b], wr_word(beats[b]));
      end
      checks++;
      if (crit_valid !== (b == crit_b) || (b == crit_b && crit_data !== beats[b])) begin
        errors++;
        $display("FAIL clean_crit%0d: valid=%b data=%h", b, crit_valid, crit_data);
      end
    end
    bus_rsp_valid = 1'b0;
    tick();
    checks++;
    if ({lsu_dc_tag_wren, dc_rw_tag_addr, dc_tag_valid_wr, fill_done, fill_err, dc_wr_en, miss_ready}
        !== {4'b0010, 30'h400, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL clean_tag: wren=%b addr=%h valid=%b done=%b err=%b wr_en=%b ready=%b",
               lsu_dc_tag_wren, dc_rw_tag_addr, dc_tag_valid_wr, fill_done, fill_err, dc_wr_en, miss_ready);
    end
    tick();
    checks++;
    if ({fill_done, lsu_dc_tag_wren, miss_ready} !== {1'b0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL clean_after_tag: done=%b wren=%b ready=%b", fill_done, lsu_dc_tag_wren, miss_ready);
    end
  endtask

  task automatic test_error_fill();
    int writes;
    writes = 0;
    start_miss(30'h402, 4'b0010);
    grant();
    for (int b = 0; b < 4; b++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = beats[b];
      bus_rsp_err   = (b == 2);
      tick();
      if (dc_wr_en === 4'b0010) writes++;
    end
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    checks++;
    if (writes != 4) begin
      errors++;
      $display("FAIL err_write_count: got %0d required 4", writes);
    end
    tick();
    checks++;
    if ({lsu_dc_tag_wren, dc_tag_valid_wr, fill_done, fill_err} !== {4'b0010, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL err_tag: wren=%b valid=%b done=%b err=%b required 0010 0 1 1",
               lsu_dc_tag_wren, dc_tag_valid_wr, fill_done, fill_err);
    end
    tick();
    checks++;
    if ({fill_err, fill_done} !== 2'b00) begin
      errors++;
      $display("FAIL err_pulse_end: err=%b done=%b required 0 0", fill_err, fill_done);
    end
  endtask

  task automatic test_parity();
    logic [63:0] pb [4];
    logic [67:0] exp_w [2];
    pb = '{64'hFFFF_0001_0000_0001, 64'h0000_0003_8000_0000, 64'h0, 64'h0};
    exp_w = '{{2'b01, 32'hFFFF_0001, 2'b01, 32'h0000_0001},
              {2'b00, 32'h0000_0003, 2'b10, 32'h8000_0000}};
    start_miss(30'h0, 4'b1000);
    grant();
    for (int b = 0; b < 4; b++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = pb[b];
      tick();
      if (b < 2) begin
        checks++;
        if (dc_wr_data !== exp_w[b]) begin
          errors++;
          $display("FAIL parity%0d: got %h required %h", b, dc_wr_data, exp_w[b]);
        end
      end
    end
    bus_rsp_valid = 1'b0;
    tick();
    checks++;
    if ({fill_done, lsu_dc_tag_wren} !== {1'b1, 4'b1000}) begin
      errors++;
      $display("FAIL parity_done: done=%b wren=%b", fill_done, lsu_dc_tag_wren);
    end
    tick();
  endtask

  task automatic test_cwf_order();
    logic [29:0] exp_a [4];
    int crit_b;
    if (CWF) begin
      exp_a = '{30'h406, 30'h400, 30'h402, 30'h404};
      crit_b = 0;
    end else begin
      exp_a = '{30'h400, 30'h402, 30'h404, 30'h406};
      crit_b = 3;
    end
    start_miss(30'h406, 4'b0001);
    checks++;
    if (bus_req_addr !== (CWF ? 29'h203 : 29'h200)) begin
      errors++;
      $display("FAIL order_req_addr: got %h", bus_req_addr);
    end
    grant();
    for (int b = 0; b < 4; b++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = beats[b];
      tick();
      checks++;
      if ({dc_wr_en, dc_rw_addr, crit_valid} !== {4'b0001, exp_a[b], 1'(b == crit_b)}) begin
        errors++;
        $display("FAIL order_write%0d: en=%b addr=%h crit=%b required addr=%h", b, dc_wr_en, dc_rw_addr,
                 crit_valid, exp_a[b]);
      end
      if (b == crit_b) begin
        checks++;
        if (crit_data !== beats[b]) begin
          errors++;
          $display("FAIL order_crit_data: got %h required %h", crit_data, beats[b]);
        end
      end
    end
    bus_rsp_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_req_stall();
    logic [28:0] exp_ra;
    int bad;
    bad = 0;
    exp_ra = CWF ? 29'h201 : 29'h200;
    start_miss(30'h402, 4'b0100);
    for (int c = 0; c < 6; c++) begin
      if (bus_req_valid !== 1'b1 || bus_req_addr !== exp_ra || dc_wr_en !== 4'b0000) bad++;
      bus_rsp_valid = (c < 5);
      bus_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      if (c < 5) tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d of 6 cycles bad (valid=%b addr=%h wr_en=%b)", bad, bus_req_valid,
               bus_req_addr, dc_wr_en);
    end
    bus_rsp_valid = 1'b0;
    grant();
    checks++;
    if ({bus_req_valid, dc_wr_en} !== {1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL stall_grant: valid=%b wr_en=%b", bus_req_valid, dc_wr_en);
    end
    for (int b = 0; b < 4; b++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = beats[b];
      tick();
    end
    bus_rsp_valid = 1'b0;
    tick();
    checks++;
    if ({lsu_dc_tag_wren, dc_tag_valid_wr, fill_done} !== {4'b0100, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL stall_tag: wren=%b valid=%b done=%b", lsu_dc_tag_wren, dc_tag_valid_wr, fill_done);
    end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    int bad;
    bad = 0;
    start_miss(30'h402, 4'b0010);
    grant();
    for (int b = 0; b < 2; b++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = beats[b];
      tick();
    end
    checks++;
    if (dc_wr_en !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_beat2: wr_en=%b required 0010", dc_wr_en);
    end
    rst_l = 1'b0;
    bus_rsp_data = beats[2];
    tick();
    checks++;
    if ({dc_wr_en, lsu_dc_tag_wren, fill_done, miss_ready, crit_valid} !== '0) begin
      errors++;
      $display("FAIL midrst_in_reset: wr_en=%b wren=%b done=%b ready=%b", dc_wr_en, lsu_dc_tag_wren,
               fill_done, miss_ready);
    end
    tick();
    rst_l = 1'b1;
    bus_rsp_data = beats[3];
    tick();
    checks++;
    if ({miss_ready, dc_wr_en} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL midrst_release: ready=%b wr_en=%b required 1 0000", miss_ready, dc_wr_en);
    end
    bus_rsp_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dc_wr_en !== 4'b0000 || lsu_dc_tag_wren !== 4'b0000 || fill_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_no_writes: %0d bad cycles", bad);
    end
  endtask

  task automatic test_back_to_back();
    start_miss(30'h800, 4'b0001);
    grant();
    for (int b = 0; b < 4; b++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = beats[b];
      tick();
    end
    bus_rsp_valid = 1'b0;
    miss_valid = 1'b1;
    miss_addr  = 30'h40A;
    miss_way   = 4'b1000;
    tick();
    checks++;
    if ({lsu_dc_tag_wren, dc_rw_tag_addr, miss_ready} !== {4'b0001, 30'h800, 1'b0}) begin
      errors++;
      $display("FAIL b2b_tag: wren=%b addr=%h ready=%b", lsu_dc_tag_wren, dc_rw_tag_addr, miss_ready);
    end
    tick();
    checks++;
    if ({miss_ready, bus_req_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_ready: ready=%b req_valid=%b required 1 0", miss_ready, bus_req_valid);
    end
    tick();
    miss_valid = 1'b0;
    checks++;
    if ({bus_req_valid, bus_req_addr} !== {1'b1, (CWF ? 29'h205 : 29'h204)}) begin
      errors++;
      $display("FAIL b2b_req: valid=%b addr=%h", bus_req_valid, bus_req_addr);
    end
    grant();
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = beats[0];
    tick();
    bus_rsp_valid = 1'b0;
    checks++;
    if ({dc_wr_en, dc_rw_addr} !== {4'b1000, (CWF ? 30'h40A : 30'h408)}) begin
      errors++;
      $display("FAIL b2b_write: en=%b addr=%h", dc_wr_en, dc_rw_addr);
    end
    for (int b = 1; b < 4; b++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = beats[b];
      tick();
    end
    bus_rsp_valid = 1'b0;
    tick();
    checks++;
    if ({lsu_dc_tag_wren, dc_rw_tag_addr, fill_done} !== {4'b1000, 30'h408, 1'b1}) begin
      errors++;
      $display("FAIL b2b_tag2: wren=%b addr=%h done=%b", lsu_dc_tag_wren, dc_rw_tag_addr, fill_done);
    end
    tick();
  endtask

  initial begin
    beats = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_F0F0_F0F1, 64'h8000_0000_0000_0003};
    rst_l         = 1'b0;
    miss_valid    = 1'b0;
    miss_addr     = '0;
    miss_way      = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = '0;
    bus_rsp_err   = 1'b0;
    tick();
    test_reset();
    test_clean_fill();
    test_error_fill();
    test_parity();
    test_cwf_order();
    test_req_stall();
    test_reset_mid_fill();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
